// File: rtl/fnd_scan_counter.sv
// fnd_scan_counter
//   Four-digit (DIGITS) BCD up/down counter driven by raw pushbuttons, with
//   a time-multiplexed scan output that feeds a 7-segment FND decoder.
//
// Ports
//   clk        : system clock, everything on the rising edge
//   rst_n      : synchronous active-low reset
//   btn_up     : raw increment button (active-high, asynchronous)
//   btn_down   : raw decrement button (active-high, asynchronous)
//   btn_clr    : raw clear button (active-high, asynchronous)
//   bcd_out    : registered BCD digit of the currently scanned position
//   dig_sel_n  : registered one-cold digit select, bit 0 = least significant
//   count_val  : packed BCD count, nibble i = digit i
//   wrap       : one-cycle pulse when the count wraps in either direction
//
// Configuration
//   FND_SCAN_LZB_EN : when defined, leading-zero digits (i > 0) stay dark
//                     for their whole slot; digit 0 is always lit.

module fnd_scan_counter #(
  parameter int DIGITS     = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int DEB_CYCLES = 500000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  btn_up,
  input  logic                  btn_down,
  input  logic                  btn_clr,
  output logic [3:0]            bcd_out,
  output logic [DIGITS-1:0]     dig_sel_n,
  output logic [4*DIGITS-1:0]   count_val,
  output logic                  wrap
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(DEB_CYCLES + 1);

  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
  localparam logic [DW-1:0] DEB_ONE  = DW'(1'b1);
  localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] PRE_ONE  = PW'(1'b1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
  localparam logic [IW-1:0] IDX_ONE  = IW'(1'b1);

  // Button slots inside the 3-bit button vectors
  localparam int B_UP   = 0;
  localparam int B_DOWN = 1;
  localparam int B_CLR  = 2;

  logic [2:0]               btn_raw_s;
  logic [2:0]               sync1_r;
  logic [2:0]               sync2_r;
  logic [2:0]               stable_r;
  logic [2:0]               stable_d_r;
  logic [2:0]               press_r;
  logic [DW-1:0]            deb_cnt_r [3];

  logic [DIGITS-1:0][3:0]   count_r;
  logic [DIGITS-1:0][3:0]   inc_s;
  logic [DIGITS-1:0][3:0]   dec_s;
  logic [DIGITS-1:0][3:0]   count_nxt_s;
  logic                     inc_carry_s;
  logic                     dec_borrow_s;
  logic                     wrap_nxt_s;
  logic                     wrap_r;

  logic [PW-1:0]            presc_r;
  logic [IW-1:0]            idx_r;
  logic [DIGITS-1:0]        blank_s;
  logic [DIGITS-1:0]        sel_nxt_s;
  logic [3:0]               bcd_nxt_s;
  logic [DIGITS-1:0]        sel_r;
  logic [3:0]               bcd_r;

  assign btn_raw_s = {btn_clr, btn_down, btn_up};

  // Synchronize, debounce and rising-edge detect the three buttons
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_r    <= 3'b000;
      sync2_r    <= 3'b000;
      stable_r   <= 3'b000;
      stable_d_r <= 3'b000;
      press_r    <= 3'b000;
      for (int b = 0; b < 3; b++) begin
        deb_cnt_r[b] <= {DW{1'b0}};
      end
    end else begin
      sync1_r    <= btn_raw_s;
      sync2_r    <= sync1_r;
      stable_d_r <= stable_r;
      // Registered edge detect: one extra cycle between acceptance and use
      press_r    <= stable_r & ~stable_d_r;
      for (int b = 0; b < 3; b++) begin
        if (sync2_r[b] == stable_r[b]) begin
          deb_cnt_r[b] <= {DW{1'b0}};
        end else if (deb_cnt_r[b] == DEB_LAST) begin
          // This sample is the DEB_CYCLES-th consecutive differing one
          stable_r[b]  <= sync2_r[b];
          deb_cnt_r[b] <= {DW{1'b0}};
        end else begin
          deb_cnt_r[b] <= deb_cnt_r[b] + DEB_ONE;
        end
      end
    end
  end

  // Decimal increment/decrement ripples across all digits
  always_comb begin
    inc_s        = count_r;
    dec_s        = count_r;
    inc_carry_s  = 1'b1;
    dec_borrow_s = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (inc_carry_s) begin
        if (count_r[i] >= 4'd9) begin
          inc_s[i] = 4'd0;
        end else begin
          inc_s[i]    = count_r[i] + 4'd1;
          inc_carry_s = 1'b0;
        end
      end else begin
        inc_s[i] = count_r[i];
      end
      if (dec_borrow_s) begin
        if (count_r[i] == 4'd0) begin
          dec_s[i] = 4'd9;
        end else if (count_r[i] > 4'd9) begin
          // Never expected; folds any corrupted digit back into BCD range
          dec_s[i]     = 4'd9;
          dec_borrow_s = 1'b0;
        end else begin
          dec_s[i]     = count_r[i] - 4'd1;
          dec_borrow_s = 1'b0;
        end
      end else begin
        dec_s[i] = count_r[i];
      end
    end
  end

  // Counter update priority: clear, then up+down cancel, then up, then down
  always_comb begin
    count_nxt_s = count_r;
    wrap_nxt_s  = 1'b0;
    if (press_r[B_CLR]) begin
      count_nxt_s = {(4*DIGITS){1'b0}};
      wrap_nxt_s  = 1'b0;
    end else if (press_r[B_UP] && press_r[B_DOWN]) begin
      count_nxt_s = count_r;
      wrap_nxt_s  = 1'b0;
    end else if (press_r[B_UP]) begin
      count_nxt_s = inc_s;
      wrap_nxt_s  = inc_carry_s;
    end else if (press_r[B_DOWN]) begin
      count_nxt_s = dec_s;
      wrap_nxt_s  = dec_borrow_s;
    end else begin
      count_nxt_s = count_r;
      wrap_nxt_s  = 1'b0;
    end
  end

  // Count and wrap registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_r <= {(4*DIGITS){1'b0}};
      wrap_r  <= 1'b0;
    end else begin
      count_r <= count_nxt_s;
      wrap_r  <= wrap_nxt_s;
    end
  end

`ifdef FND_SCAN_LZB_EN
  // Leading-zero mask: digit i is dark when it and every higher digit is 0
  always_comb begin
    logic upper_zero;
    blank_s    = {DIGITS{1'b0}};
    upper_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      upper_zero = upper_zero & (count_r[i] == 4'd0);
      blank_s[i] = upper_zero;
    end
  end
`else
  assign blank_s = {DIGITS{1'b0}};
`endif

  // Digit mux and one-cold select; prescaler 0 is the ghost-suppression slot
  always_comb begin
    bcd_nxt_s = count_r[idx_r];
    sel_nxt_s = {DIGITS{1'b1}};
    if (presc_r == {PW{1'b0}}) begin
      sel_nxt_s = {DIGITS{1'b1}};
    end else begin
      for (int i = 0; i < DIGITS; i++) begin
        sel_nxt_s[i] = (idx_r == IW'(i)) ? blank_s[i] : 1'b1;
      end
    end
  end

  // Scan prescaler, digit index and registered display outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_r <= {PW{1'b0}};
      idx_r   <= {IW{1'b0}};
      bcd_r   <= 4'h0;
      sel_r   <= {DIGITS{1'b1}};
    end else begin
      if (presc_r == PRE_LAST) begin
        presc_r <= {PW{1'b0}};
        idx_r   <= (idx_r == IDX_LAST) ? {IW{1'b0}} : (idx_r + IDX_ONE);
      end else begin
        presc_r <= presc_r + PRE_ONE;
        idx_r   <= idx_r;
      end
      bcd_r <= bcd_nxt_s;
      sel_r <= sel_nxt_s;
    end
  end

  assign bcd_out   = bcd_r;
  assign dig_sel_n = sel_r;
  assign count_val = count_r;
  assign wrap      = wrap_r;

endmodule

// File: tb/tb_fnd_scan_counter.sv
// Self-checking bench for fnd_scan_counter (DIGITS=4, SCAN_DIV=4, DEB_CYCLES=3).
// A behavioural model (integer count, sample-history debouncer, arithmetic
// scan position) is compared with the DUT every cycle; directed sequences add
// literal expectations for latency, carry, wrap, priority and scan order.

module tb_fnd_scan_counter;

  localparam int DIGITS     = 4;
  localparam int SCAN_DIV   = 4;
  localparam int DEB_CYCLES = 3;
  localparam int MOD        = 10 ** DIGITS;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                btn_up = 1'b0;
  logic                btn_down = 1'b0;
  logic                btn_clr = 1'b0;
  logic [3:0]          bcd_out;
  logic [DIGITS-1:0]   dig_sel_n;
  logic [4*DIGITS-1:0] count_val;
  logic                wrap;

  fnd_scan_counter #(
    .DIGITS    (DIGITS),
    .SCAN_DIV  (SCAN_DIV),
    .DEB_CYCLES(DEB_CYCLES)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_up   (btn_up),
    .btn_down (btn_down),
    .btn_clr  (btn_clr),
    .bcd_out  (bcd_out),
    .dig_sel_n(dig_sel_n),
    .count_val(count_val),
    .wrap     (wrap)
  );

  always #5 clk = ~clk;

  int checks_total  = 0;
  int checks_passed = 0;
  int fail_prints   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks_total++;
    if (act === exp) begin
      checks_passed++;
    end else begin
      if (fail_prints < 40) begin
        $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
      fail_prints++;
    end
  endtask

  function automatic int digit_of(input int v, input int i);
    int x;
    x = v;
    for (int k = 0; k < i; k++) x = x / 10;
    return x % 10;
  endfunction

  function automatic int pow10(input int i);
    int x;
    x = 1;
    for (int k = 0; k < i; k++) x = x * 10;
    return x;
  endfunction

  function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
    logic [4*DIGITS-1:0] r;
    for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'(digit_of(v, i));
    return r;
  endfunction

  // ---------------- behavioural model ----------------
  int                cnt_m;
  logic              wrap_m;
  logic [3:0]        bcd_m;
  logic [DIGITS-1:0] sel_m;
  int                n_m;
  bit                model_valid = 1'b0;
  bit [2:0]          hist_m [DEB_CYCLES+1]; // hist_m[k] = raw buttons k+1 edges ago
  bit [2:0]          stable_m;
  bit [2:0]          p1_m;
  bit [2:0]          p2_m;

  task automatic model_step();
    int presc;
    int idx;
    bit [2:0] flip;
    bit all_diff;
    if (!rst_n) begin
      cnt_m = 0; wrap_m = 1'b0; bcd_m = 4'h0; sel_m = {DIGITS{1'b1}};
      n_m = 0; stable_m = 3'b000; p1_m = 3'b000; p2_m = 3'b000;
      for (int k = 0; k <= DEB_CYCLES; k++) hist_m[k] = 3'b000;
      model_valid = 1'b1;
      return;
    end
    n_m++;
    // Scan position from elapsed edges since reset release
    presc = (n_m - 1) % SCAN_DIV;
    idx   = ((n_m - 1) / SCAN_DIV) % DIGITS;
    bcd_m = 4'(digit_of(cnt_m, idx));
    sel_m = {DIGITS{1'b1}};
    if (presc != 0) begin
      sel_m[idx] = 1'b0;
`ifdef FND_SCAN_LZB_EN
      if (idx > 0 && (cnt_m / pow10(idx)) == 0) sel_m[idx] = 1'b1;
`endif
    end
    // Count update from presses accepted two edges ago
    wrap_m = 1'b0;
    if (p2_m[2]) begin
      cnt_m = 0;
    end else if (p2_m[0] && p2_m[1]) begin
      cnt_m = cnt_m;
    end else if (p2_m[0]) begin
      if (cnt_m == MOD - 1) begin cnt_m = 0; wrap_m = 1'b1; end
      else cnt_m = cnt_m + 1;
    end else if (p2_m[1]) begin
      if (cnt_m == 0) begin cnt_m = MOD - 1; wrap_m = 1'b1; end
      else cnt_m = cnt_m - 1;
    end
    // Debounce: flip when the last DEB_CYCLES synchronized samples all differ
    for (int b = 0; b < 3; b++) begin
      all_diff = 1'b1;
      for (int k = 1; k <= DEB_CYCLES; k++) begin
        if (hist_m[k][b] == stable_m[b]) all_diff = 1'b0;
      end
      flip[b] = 1'b0;
      if (all_diff) begin
        stable_m[b] = ~stable_m[b];
        flip[b]     = stable_m[b];
      end
    end
    p2_m = p1_m;
    p1_m = flip;
    for (int k = DEB_CYCLES; k >= 1; k--) hist_m[k] = hist_m[k-1];
    hist_m[0] = {btn_clr, btn_down, btn_up};
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Per-cycle compare against the model
  initial begin
    forever begin
      @(negedge clk);
      if (model_valid) begin
        check("count_val", 32'(count_val), 32'(to_bcd(cnt_m)));
        check("wrap", 32'(wrap), 32'(wrap_m));
        check("bcd_out", 32'(bcd_out), 32'(bcd_m));
        check("dig_sel_n", 32'(dig_sel_n), 32'(sel_m));
      end
    end
  end

  // ---------------- directed + random stimulus ----------------
  logic [3:0] exp_sel [16] = '{4'b1111, 4'b1110, 4'b1110, 4'b1110,
                               4'b1111, 4'b1101, 4'b1101, 4'b1101,
                               4'b1111, 4'b1011, 4'b1011, 4'b1011,
                               4'b1111, 4'b0111, 4'b0111, 4'b0111};
  int hold_r [3];

  task automatic press(input logic u, input logic d, input logic c, output int wraps);
    wraps = 0;
    btn_up = u; btn_down = d; btn_clr = c;
    repeat (6) begin @(negedge clk); wraps += int'(wrap); end
    btn_up = 1'b0; btn_down = 1'b0; btn_clr = 1'b0;
    repeat (6) begin @(negedge clk); wraps += int'(wrap); end
  endtask

  initial begin
    int w;
    int lit;
    logic [2:0] lvl;
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_count", 32'(count_val), 32'h0);
    check("rst_wrap", 32'(wrap), 32'h0);
    check("rst_bcd", 32'(bcd_out), 32'h0);
    check("rst_sel", 32'(dig_sel_n), 32'hF);
    rst_n = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      check("scan_seq", 32'(dig_sel_n), 32'(exp_sel[k]));
    end

    // Short glitch is ignored
    btn_up = 1'b1;
    repeat (2) @(negedge clk);
    btn_up = 1'b0;
    repeat (10) @(negedge clk);
    check("glitch_count", 32'(count_val), 32'h0);

    // Held button: one step, 6 edges after first high sample
    btn_up = 1'b1;
    repeat (6) @(negedge clk);
    check("latency_early", 32'(count_val), 32'h0);
    @(negedge clk);
    check("latency_hit", 32'(count_val), 32'h0001);
    repeat (4) @(negedge clk);
    check("hold_no_repeat", 32'(count_val), 32'h0001);
    btn_up = 1'b0;
    repeat (8) @(negedge clk);
    check("release_no_step", 32'(count_val), 32'h0001);

    press(1'b0, 1'b0, 1'b1, w);
    check("clr", 32'(count_val), 32'h0);
    press(1'b0, 1'b1, 1'b0, w);
    check("down_wrap_val", 32'(count_val), 32'h9999);
    check("down_wrap_pulses", 32'(w), 32'd1);
    press(1'b1, 1'b0, 1'b0, w);
    check("up_wrap_val", 32'(count_val), 32'h0000);
    check("up_wrap_pulses", 32'(w), 32'd1);

    for (int i = 0; i < 99; i++) press(1'b1, 1'b0, 1'b0, w);
    check("count_0099", 32'(count_val), 32'h0099);
    press(1'b1, 1'b0, 1'b0, w);
    check("carry_0100", 32'(count_val), 32'h0100);
    check("carry_no_wrap", 32'(w), 32'd0);

    press(1'b0, 1'b0, 1'b1, w);
    for (int i = 0; i < 42; i++) press(1'b1, 1'b0, 1'b0, w);
    check("count_0042", 32'(count_val), 32'h0042);
    press(1'b1, 1'b0, 1'b1, w);
    check("clr_up_val", 32'(count_val), 32'h0000);
    check("clr_up_no_wrap", 32'(w), 32'd0);
    press(1'b1, 1'b0, 1'b0, w);
    press(1'b1, 1'b1, 1'b0, w);
    check("up_down_cancel", 32'(count_val), 32'h0001);

    press(1'b0, 1'b0, 1'b1, w);
    for (int i = 0; i < 1234; i++) press(1'b1, 1'b0, 1'b0, w);
    check("count_1234", 32'(count_val), 32'h1234);
    lit = 0;
    repeat (16) begin
      @(negedge clk);
      case (dig_sel_n)
        4'b1110: begin check("scan_d0", 32'(bcd_out), 32'h4); lit++; end
        4'b1101: begin check("scan_d1", 32'(bcd_out), 32'h3); lit++; end
        4'b1011: begin check("scan_d2", 32'(bcd_out), 32'h2); lit++; end
        4'b0111: begin check("scan_d3", 32'(bcd_out), 32'h1); lit++; end
        default: ;
      endcase
    end
    check("scan_lit_cycles", 32'(lit), 32'd12);

    // Random buttons with occasional mid-operation reset
    for (int b = 0; b < 3; b++) hold_r[b] = 0;
    lvl = 3'b000;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst_n = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
      for (int b = 0; b < 3; b++) begin
        if (hold_r[b] == 0) begin
          if (b == 2) lvl[b] = ($urandom_range(0, 7) == 0);
          else lvl[b] = 1'($urandom_range(0, 1));
          hold_r[b] = $urandom_range(1, 9);
        end else begin
          hold_r[b] = hold_r[b] - 1;
        end
      end
      btn_up = lvl[0]; btn_down = lvl[1]; btn_clr = lvl[2];
    end
    @(negedge clk);
    rst_n = 1'b1; btn_up = 1'b0; btn_down = 1'b0; btn_clr = 1'b0;
    repeat (20) @(negedge clk);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/fnd_scan_counter.md
# fnd_scan_counter

Four-digit BCD up/down counter with button debouncing and time-multiplexed digit scanning. It sits directly upstream of the 7-segment FND decoder. Each scan slot it presents one 4-bit BCD digit on `bcd_out`, which feeds the decoder's switch input, and drives the matching active-low common-anode digit select. Buttons are raw board pushbuttons; all state is synchronous to one clock.

## Interface
- `DIGITS`, 4: number of BCD digits counted and scanned; legal range 2–8.
- `SCAN_DIV`, 50000: clock cycles per digit scan slot; minimum 2.
- `DEB_CYCLES`, 500000: consecutive stable synchronized samples required to accept a button level change; minimum 1.

- `clk` input 1: system clock; all logic is on its rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `btn_up` input 1: raw increment button, active-high, asynchronous to `clk`.
- `btn_down` input 1: raw decrement button, active-high, asynchronous.
- `btn_clr` input 1: raw clear button, active-high, asynchronous.
- `bcd_out` output 4: BCD digit for the currently selected position; goes to the decoder.
- `dig_sel_n` output DIGITS: one-cold digit select; bit i low lights digit i; bit 0 is the least-significant digit.
- `count_val` output 4*DIGITS: packed BCD count; nibble i is digit i.
- `wrap` output 1: one-cycle pulse when the counter wraps in either direction.

## Operation
- **Input path (per button):**
  - 2-flop synchronizer feeds a debouncer.
  - The debouncer holds a `stable` level and a counter.
  - When the synchronized sample differs from `stable`, the counter increments; when it equals `stable`, the counter resets to 0.
  - When the counter reaches DEB_CYCLES, `stable` takes the sample and the counter resets.
  - A 0→1 transition of `stable` produces a one-cycle press pulse. Release produces nothing.
- **Counter update priority (per cycle):**
  - clr pulse: all digits go to 0; `wrap` = 0.
  - up and down pulses together: no change.
  - up pulse: decimal increment with per-digit carry (9→0 carries into the next digit).
  - down pulse: decimal decrement with per-digit borrow (0→9 borrows).
- **Wrap:**
  - Up from all-9s gives all-0s. Down from all-0s gives all-9s.
  - `wrap` is high for exactly the cycle in which the wrapped value is registered.
  - Digits never hold non-BCD values (A–F).
- **Scan:**
  - Prescaler counts 0..SCAN_DIV-1 and wraps.
  - When it wraps, the digit index advances 0→1→…→DIGITS-1→0.
  - Ghost suppression: while the prescaler = 0, `dig_sel_n` is all ones (dead cycle).
  - Otherwise bit[index] is low and `bcd_out` = nibble[index] of `count_val`.
  - During the dead cycle, `bcd_out` already shows the new index's digit.

## Timing
- **Reset values:**
  - `count_val` = 0, `wrap` = 0, `bcd_out` = 4'h0, `dig_sel_n` = all ones.
  - Prescaler = 0, digit index = 0, debouncer `stable` = 0, debouncer counters = 0, synchronizers = 0.
- **Button latency:** raw input first sampled high and held at edge t → `count_val` changes at edge t+DEB_CYCLES+3 (2 synchronizer cycles, DEB_CYCLES debounce cycles, pulse and update).
- **Glitches:** a pulse shorter than DEB_CYCLES synchronized cycles has no effect.
- **Output register latency:** `bcd_out` and `dig_sel_n` are registered; they reflect `count_val` and the index one cycle later.
- **First scan after reset release:**
  - First edge: prescaler 0, dead cycle.
  - Next edge: digit 0 selected.
  - Each digit is lit SCAN_DIV-1 cycles per slot.
- **Reset mid-operation:** asserting `rst_n` low at any edge restores all reset values at that edge. This includes aborting a partial debounce and a pending pulse.
- **Holding a button:** yields exactly one count step; no auto-repeat.

## Configuration
- Macro: `FND_SCAN_LZB_EN` (leading-zero blanking).
- **Defined:** digit i > 0 stays dark (`dig_sel_n[i]` = 1 for its whole slot) when nibble i and all higher nibbles are 0. Digit 0 is always lit. Slot timing and `bcd_out` are unchanged.
- **Undefined:** every digit is lit in its slot regardless of value.

## Test plan
Bench settings: DIGITS=4, SCAN_DIV=4, DEB_CYCLES=3.

- **Reset:** hold `rst_n` low 5 cycles, then release → all outputs at reset values; first `dig_sel_n`=4'b1110 appears 2 edges after release; pattern 1110/1101/1011/0111, each lit 3 cycles, separated by 1-cycle 4'b1111.
- **Debounce:** `btn_up` high 2 cycles then low → `count_val` stays 16'h0000. `btn_up` held high 10 cycles → `count_val`=16'h0001 exactly 6 edges after first high sample; no further change while held.
- **Carry and wrap:** from 16'h0099 press up → 16'h0100. From 16'h9999 press up → 16'h0000 with a single-cycle `wrap`. From 16'h0000 press down → 16'h9999 and `wrap` pulses.
- **Priority:** up+down pressed on the same edge → no change. clr+up together at 16'h0042 → 16'h0000 and no `wrap`.
- **Scan data:** `count_val`=16'h1234 → `bcd_out` 4,3,2,1 in slots for `dig_sel_n` 1110,1101,1011,0111.
- **Blanking:** with `FND_SCAN_LZB_EN` and `count_val`=16'h0070 → only slots 0 and 1 lit; slots 2 and 3 give `dig_sel_n`=4'b1111. Without the macro → all four digits lit.
